// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the round-robin timer arbiter: FSM encoding,
// default length limit and the length clamp helper.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ta_state_e;

    localparam int unsigned TA_MAXLEN_DEFAULT = 9;

    // Requested lengths above the honoured maximum saturate rather than wrap.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        logic [3:0] res;
        if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_arbiter_count4.sv
// Shared 4-bit counter: synchronous clear has priority over enable,
// otherwise the value holds.
module count4 (
    input  logic       clk,
    input  logic       r,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] Q
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (en) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q = cnt_q;

endmodule

// File: rtl/timer_arbiter.sv
// Two-requester round-robin arbiter for one shared up-counter; the winner's
// length is counted out and completion is signalled with a one-cycle pulse.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int unsigned MAXLEN = TA_MAXLEN_DEFAULT
) (
    input  logic       clk,
    input  logic       r,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic [3:0] Q
);

    localparam logic [3:0] MAX_LEN4 = (MAXLEN > 15) ? 4'd15 : 4'(MAXLEN);

    ta_state_e  state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       owner_q, owner_d;
    logic [3:0] len_q, len_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       busy_q, busy_d;

    logic       cnt_clr_s;
    logic       cnt_en_s;
    logic [3:0] cnt_s;
    logic       owner_req_s;
    logic [3:0] owner_len_s;

    assign owner_req_s = owner_q ? req1 : req0;
    assign owner_len_s = owner_q ? len1 : len0;

    count4 u_count4 (
        .clk (clk),
        .r   (r),
        .clr (cnt_clr_s),
        .en  (cnt_en_s),
        .Q   (cnt_s)
    );

    // Next-state, arbitration and counter control.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        len_d     = len_q;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_LOAD;
                    if (req0 && req1) begin
                        owner_d = ptr_q;
                    end else if (req1) begin
                        owner_d = 1'b1;
                    end else begin
                        owner_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // An abort leaves the counter untouched.
                if (!owner_req_s) begin
                    state_d = ST_IDLE;
                    ptr_d   = ~owner_q;
                end else begin
                    len_d     = clamp_len(owner_len_s, MAX_LEN4);
                    cnt_clr_s = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!owner_req_s) begin
                    state_d = ST_IDLE;
                    ptr_d   = ~owner_q;
                end else if (cnt_s == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = ~owner_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        gnt0_d  = busy_d && !owner_d;
        gnt1_d  = busy_d && owner_d;
        done0_d = (state_d == ST_DONE) && !owner_d;
        done1_d = (state_d == ST_DONE) && owner_d;
    end

    // State, arbitration and output registers.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            len_q   <= 4'd0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign busy  = busy_q;
    assign Q     = cnt_s;

endmodule
